// File: rtl/data_mem_arbiter_if.sv
// Bundle of both cores' data-memory ports, the shared memory port and busy.
// "slave" is the arbiter's view; "master" is the cores-plus-memory side.
interface data_mem_arbiter_if #(
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_ADDR = 32
);
  logic              c0_req;
  logic              c0_we;
  logic [W_ADDR-1:0] c0_addr;
  logic [W_DATA-1:0] c0_wdata;
  logic [W_DATA-1:0] c0_rdata;
  logic              c0_ready;
  logic              c1_req;
  logic              c1_we;
  logic [W_ADDR-1:0] c1_addr;
  logic [W_DATA-1:0] c1_wdata;
  logic [W_DATA-1:0] c1_rdata;
  logic              c1_ready;
  logic              mem_en;
  logic              mem_we;
  logic [W_ADDR-1:0] mem_addr;
  logic [W_DATA-1:0] mem_wdata;
  logic [W_DATA-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_rdata, c0_ready,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_rdata, c1_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_rdata, c0_ready,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_rdata, c1_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-core arbiter serialising load/store requests onto one synchronous data memory.
// Define DATA_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise core 0 has fixed priority.
module data_mem_arbiter #(
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  logic [1:0]        state_r;
  logic [2:0]        cnt_r;
  logic              owner_r;
  logic              last_owner_r;
  logic              busy_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [W_ADDR-1:0] mem_addr_r;
  logic [W_DATA-1:0] mem_wdata_r;
  logic [W_DATA-1:0] c0_rdata_r;
  logic [W_DATA-1:0] c1_rdata_r;
  logic              c0_ready_r;
  logic              c1_ready_r;

  logic              any_req_s;
  logic              grant_s;
  logic              grant_we_s;
  logic [W_ADDR-1:0] grant_addr_s;
  logic [W_DATA-1:0] grant_wdata_s;

`ifndef DATA_ARB_ROUND_ROBIN_EN
  logic last_owner_unused_s;
  assign last_owner_unused_s = last_owner_r;
`endif

  // Owner selection and the command fields latched at grant
  always_comb begin
    any_req_s = bus.c0_req | bus.c1_req;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    if (bus.c0_req && bus.c1_req) begin
      grant_s = ~last_owner_r;
    end else begin
      grant_s = bus.c1_req;
    end
`else
    grant_s = ~bus.c0_req;
`endif
    if (grant_s) begin
      grant_we_s    = bus.c1_we;
      grant_addr_s  = bus.c1_addr;
      grant_wdata_s = bus.c1_wdata;
    end else begin
      grant_we_s    = bus.c0_we;
      grant_addr_s  = bus.c0_addr;
      grant_wdata_s = bus.c0_wdata;
    end
  end

  // Transaction FSM, memory port registers and per-core completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 3'd0;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      busy_r       <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      c0_rdata_r   <= '0;
      c1_rdata_r   <= '0;
      c0_ready_r   <= 1'b0;
      c1_ready_r   <= 1'b0;
    end else begin
      c0_ready_r <= 1'b0;
      c1_ready_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            owner_r     <= grant_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= grant_we_s;
            mem_addr_r  <= grant_addr_s;
            mem_wdata_r <= grant_wdata_s;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en_r <= 1'b0;
          cnt_r    <= LAT_INIT;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 3'd1;
          // Count 1 is the cycle mem_rdata is valid for this access
          if (cnt_r == 3'd1) begin
            if (!mem_we_r) begin
              if (owner_r) begin
                c1_rdata_r <= bus.mem_rdata;
              end else begin
                c0_rdata_r <= bus.mem_rdata;
              end
            end
            if (owner_r) begin
              c1_ready_r <= 1'b1;
            end else begin
              c0_ready_r <= 1'b1;
            end
            last_owner_r <= owner_r;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= 3'd0;
          mem_en_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.c0_rdata  = c0_rdata_r;
  assign bus.c1_rdata  = c1_rdata_r;
  assign bus.c0_ready  = c0_ready_r;
  assign bus.c1_ready  = c1_ready_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: three instances with MEM_LAT 1, 2 and 3.
// Tie-break expectations follow DATA_ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   c1_pulses;

  data_mem_arbiter_if #(.W_DATA(32), .W_ADDR(32)) b1 ();
  data_mem_arbiter_if #(.W_DATA(32), .W_ADDR(32)) b2 ();
  data_mem_arbiter_if #(.W_DATA(32), .W_ADDR(32)) b3 ();

  data_mem_arbiter #(.W_DATA(32), .W_ADDR(32), .MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_arbiter #(.W_DATA(32), .W_ADDR(32), .MEM_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  data_mem_arbiter #(.W_DATA(32), .W_ADDR(32), .MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    if (addr == 32'h0000_0040) return 32'hDEAD_BEEF;
    return addr ^ 32'h5A5A_0000;
  endfunction

  // Read data appears only in the one cycle it is valid; any other cycle shows a marker
  function automatic logic [31:0] rd_next(input logic en, input logic we, input logic [31:0] addr);
    if (en && !we) return mem_fn(addr);
    return 32'hBAD0_BAD0;
  endfunction

  logic [31:0] p1;
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];

  always_ff @(posedge clk) p1 <= rd_next(b1.mem_en, b1.mem_we, b1.mem_addr);

  always_ff @(posedge clk) begin
    p2[0] <= rd_next(b2.mem_en, b2.mem_we, b2.mem_addr);
    p2[1] <= p2[0];
  end

  always_ff @(posedge clk) begin
    p3[0] <= rd_next(b3.mem_en, b3.mem_we, b3.mem_addr);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign b1.mem_rdata = p1;
  assign b2.mem_rdata = p2[1];
  assign b3.mem_rdata = p3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        rr;
    logic        own;
    logic [31:0] exp_addr;
    errors    = 0;
    checks    = 0;
    c1_pulses = 0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b1;
    b1.c0_req = 1'b0; b1.c0_we = 1'b0; b1.c0_addr = 32'h0; b1.c0_wdata = 32'h0;
    b1.c1_req = 1'b0; b1.c1_we = 1'b0; b1.c1_addr = 32'h0; b1.c1_wdata = 32'h0;
    b2.c0_req = 1'b0; b2.c0_we = 1'b0; b2.c0_addr = 32'h0; b2.c0_wdata = 32'h0;
    b2.c1_req = 1'b0; b2.c1_we = 1'b0; b2.c1_addr = 32'h0; b2.c1_wdata = 32'h0;
    b3.c0_req = 1'b0; b3.c0_we = 1'b0; b3.c0_addr = 32'h0; b3.c0_wdata = 32'h0;
    b3.c1_req = 1'b0; b3.c1_we = 1'b0; b3.c1_addr = 32'h0; b3.c1_wdata = 32'h0;
    tick();
    tick();
    chk("rst_mem_en", {31'd0, b1.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, b1.mem_we}, 32'd0);
    chk("rst_mem_addr", b1.mem_addr, 32'd0);
    chk("rst_mem_wdata", b1.mem_wdata, 32'd0);
    chk("rst_c0_rdata", b1.c0_rdata, 32'd0);
    chk("rst_c1_rdata", b1.c1_rdata, 32'd0);
    chk("rst_readys", {30'd0, b1.c0_ready, b1.c1_ready}, 32'd0);
    chk("rst_busy", {31'd0, b1.busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Core 0 load of 0x40, MEM_LAT=1
    b1.c0_req = 1'b1; b1.c0_we = 1'b0; b1.c0_addr = 32'h0000_0040;
    tick();
    chk("ld0_mem_en", {31'd0, b1.mem_en}, 32'd1);
    chk("ld0_mem_addr", b1.mem_addr, 32'h0000_0040);
    chk("ld0_mem_we", {31'd0, b1.mem_we}, 32'd0);
    chk("ld0_busy_t1", {31'd0, b1.busy}, 32'd1);
    tick();
    chk("ld0_mem_en_t2", {31'd0, b1.mem_en}, 32'd0);
    chk("ld0_ready_t2", {31'd0, b1.c0_ready}, 32'd0);
    tick();
    chk("ld0_ready_t3", {31'd0, b1.c0_ready}, 32'd1);
    chk("ld0_rdata_t3", b1.c0_rdata, 32'hDEAD_BEEF);
    chk("ld0_busy_t3", {31'd0, b1.busy}, 32'd0);
    b1.c0_req = 1'b0;
    tick();
    chk("ld0_ready_t4", {31'd0, b1.c0_ready}, 32'd0);
    chk("ld0_idle_t4", {30'd0, b1.mem_en, b1.busy}, 32'd0);

    // Core 1 store of 0x12345678 to 0x80
    b1.c1_req = 1'b1; b1.c1_we = 1'b1; b1.c1_addr = 32'h0000_0080; b1.c1_wdata = 32'h1234_5678;
    tick();
    chk("st1_mem_en", {31'd0, b1.mem_en}, 32'd1);
    chk("st1_mem_we", {31'd0, b1.mem_we}, 32'd1);
    chk("st1_mem_addr", b1.mem_addr, 32'h0000_0080);
    chk("st1_mem_wdata", b1.mem_wdata, 32'h1234_5678);
    tick();
    chk("st1_mem_en_t2", {31'd0, b1.mem_en}, 32'd0);
    chk("st1_mem_we_hold", {31'd0, b1.mem_we}, 32'd1);
    tick();
    chk("st1_ready_t3", {31'd0, b1.c1_ready}, 32'd1);
    chk("st1_rdata_kept", b1.c1_rdata, 32'd0);
    chk("st1_c0_rdata_kept", b1.c0_rdata, 32'hDEAD_BEEF);
    chk("st1_mem_en_t3", {31'd0, b1.mem_en}, 32'd0);
    b1.c1_req = 1'b0; b1.c1_we = 1'b0;
    tick();
    chk("st1_ready_t4", {31'd0, b1.c1_ready}, 32'd0);

    // Both cores load at once: core 0 first under either tie-break
    b1.c0_req = 1'b1; b1.c0_addr = 32'h0000_0100;
    b1.c1_req = 1'b1; b1.c1_addr = 32'h0000_0200;
    tick();
    chk("both_first_addr", b1.mem_addr, 32'h0000_0100);
    tick();
    tick();
    chk("both_c0_ready", {30'd0, b1.c0_ready, b1.c1_ready}, 32'd2);
    chk("both_c0_rdata", b1.c0_rdata, 32'h5A5A_0100);
    b1.c0_req = 1'b0;
    tick();
    chk("both_second_en", {31'd0, b1.mem_en}, 32'd1);
    chk("both_second_addr", b1.mem_addr, 32'h0000_0200);
    tick();
    tick();
    chk("both_c1_ready", {30'd0, b1.c0_ready, b1.c1_ready}, 32'd1);
    chk("both_c1_rdata", b1.c1_rdata, 32'h5A5A_0200);
    chk("both_c0_rdata_kept", b1.c0_rdata, 32'h5A5A_0100);
    b1.c1_req = 1'b0;
    tick();

    // Core 0 requests continuously while core 1 also requests
    b1.c0_req = 1'b1; b1.c0_addr = 32'h0000_0300;
    b1.c1_req = 1'b1; b1.c1_addr = 32'h0000_0400;
    for (int k = 0; k < 10; k++) begin
      own = rr ? k[0] : 1'b0;
      exp_addr = own ? 32'h0000_0400 : 32'h0000_0300;
      tick();
      chk($sformatf("cont_en_%0d", k), {31'd0, b1.mem_en}, 32'd1);
      chk($sformatf("cont_addr_%0d", k), b1.mem_addr, exp_addr);
      tick();
      tick();
      chk($sformatf("cont_ready_%0d", k), {30'd0, b1.c0_ready, b1.c1_ready}, own ? 32'd1 : 32'd2);
      if (b1.c1_ready) c1_pulses++;
      if (k == 9) begin
        b1.c0_req = 1'b0;
        b1.c1_req = 1'b0;
      end
    end
    chk("cont_c1_pulses", c1_pulses, rr ? 32'd5 : 32'd0);
    tick();
    chk("cont_idle", {30'd0, b1.mem_en, b1.busy}, 32'd0);

    // Core 1 load with MEM_LAT=3
    b3.c1_req = 1'b1; b3.c1_we = 1'b0; b3.c1_addr = 32'h0000_0500;
    tick();
    chk("lat3_en_t1", {30'd0, b3.mem_en, b3.busy}, 32'd3);
    for (int t = 2; t <= 4; t++) begin
      tick();
      chk($sformatf("lat3_wait_t%0d", t), {29'd0, b3.mem_en, b3.busy, b3.c1_ready}, 32'd2);
    end
    tick();
    chk("lat3_ready_t5", {29'd0, b3.mem_en, b3.busy, b3.c1_ready}, 32'd1);
    chk("lat3_rdata_t5", b3.c1_rdata, 32'h5A5A_0500);
    b3.c1_req = 1'b0;
    tick();

    // Reset during the WAIT of a core 0 load, MEM_LAT=2
    b2.c0_req = 1'b1; b2.c0_we = 1'b0; b2.c0_addr = 32'h0000_0600;
    tick();
    chk("rmid_en_t1", {31'd0, b2.mem_en}, 32'd1);
    tick();
    chk("rmid_busy_t2", {31'd0, b2.busy}, 32'd1);
    rst = 1'b1;
    b2.c0_req = 1'b0;
    #1;
    chk("rmid_clear_busy", {30'd0, b2.busy, b2.mem_en}, 32'd0);
    chk("rmid_clear_addr", b2.mem_addr, 32'd0);
    chk("rmid_clear_ready", {30'd0, b2.c0_ready, b2.c1_ready}, 32'd0);
    tick();
    chk("rmid_ready_rst", {31'd0, b2.c0_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rmid_ready_post1", {31'd0, b2.c0_ready}, 32'd0);
    chk("rmid_rdata_post1", b2.c0_rdata, 32'd0);
    tick();
    chk("rmid_ready_post2", {30'd0, b2.c0_ready, b2.busy}, 32'd0);
    b2.c0_req = 1'b1; b2.c0_addr = 32'h0000_0040;
    tick();
    chk("rmid_fresh_en", {31'd0, b2.mem_en}, 32'd1);
    chk("rmid_fresh_addr", b2.mem_addr, 32'h0000_0040);
    tick();
    tick();
    chk("rmid_fresh_ready_early", {31'd0, b2.c0_ready}, 32'd0);
    tick();
    chk("rmid_fresh_ready", {31'd0, b2.c0_ready}, 32'd1);
    chk("rmid_fresh_rdata", b2.c0_rdata, 32'hDEAD_BEEF);
    b2.c0_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
